// File: rtl/mul_div_unit.sv
// Iterative multiply / divide unit.
// One partial product or quotient bit per busy cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_mul,
  input  logic               run_div,
  input  logic               u,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               stall,
  output logic [2*WIDTH-1:0] z,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               divz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul;
  logic               r_neg;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_mc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_run;
  logic               w_start;
  logic               w_fin;
  logic [WIDTH-1:0]   w_xmag;
  logic [WIDTH-1:0]   w_ymag;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_tr;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_nhi;
  logic [WIDTH-1:0]   w_nlo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_run   = run_mul | run_div;
  assign stall   = w_run & (r_state != S_DONE) & ~rst;
  assign w_start = (r_state == S_IDLE) & w_run;
  assign w_fin   = (r_state == S_BUSY) & (w_state_n == S_DONE);

  // Magnitudes: the multiplier folds both signs into r_neg,
  // the divider only takes |x| and keeps y unsigned.
  assign w_xmag = (u & x[WIDTH-1]) ? (~x + 1'b1) : x;
  assign w_ymag = (u & y[WIDTH-1]) ? (~y + 1'b1) : y;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Next state: run low in BUSY aborts; WIDTH busy cycles finish.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: if (w_run) w_state_n = S_BUSY;
      S_BUSY: begin
        if (!w_run)             w_state_n = S_IDLE;
        else if (r_cnt == LAST) w_state_n = S_DONE;
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // One shift-add or restoring-subtract step on {r_hi, r_lo}.
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
    w_tr   = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_tr - {1'b0, r_y};
    w_ge   = (w_tr >= {1'b0, r_y});
    if (r_mul) begin
      w_nhi = w_msum[WIDTH:1];
      w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_nhi = w_ge ? w_diff[WIDTH-1:0] : w_tr[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
    w_prod = {w_nhi, w_nlo};
  end

  // Floored-division fixup for negative dividends.
  always_comb begin
    w_quot = w_nlo;
    w_rem  = w_nhi;
    if (r_y == '0) begin
      w_quot = '1;
      w_rem  = r_x;
    end else if (r_neg) begin
      if (w_nhi != '0) begin
        w_quot = ~w_nlo;
        w_rem  = r_y - w_nhi;
      end else begin
        w_quot = ~w_nlo + 1'b1;
        w_rem  = '0;
      end
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_mul <= 1'b0;
      r_neg <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_mc  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_mul <= run_mul;
      r_neg <= run_mul ? (u & (x[WIDTH-1] ^ y[WIDTH-1]))
                       : (u & x[WIDTH-1]);
      r_x   <= x;
      r_y   <= y;
      r_mc  <= w_xmag;
      r_hi  <= '0;
      r_lo  <= run_mul ? w_ymag : w_xmag;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
    end
  end

  // Results change only on the BUSY->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      z    <= '0;
      quot <= '0;
      rem  <= '0;
      divz <= 1'b0;
    end else if (w_fin) begin
      if (r_mul) begin
        z <= r_neg ? (~w_prod + 1'b1) : w_prod;
      end else begin
        quot <= w_quot;
        rem  <= w_rem;
        divz <= (r_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32.
// Expected values are hand-computed constants.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_mul;
  logic        run_div;
  logic        u;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [63:0] z;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        divz;

  int n_run  = 0;
  int n_fail = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .run_mul (run_mul),
    .run_div (run_div),
    .u       (u),
    .x       (x),
    .y       (y),
    .stall   (stall),
    .z       (z),
    .quot    (quot),
    .rem     (rem),
    .divz    (divz)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic uu,
                       input logic [31:0] a, input logic [31:0] b);
    run_mul = m;
    run_div = ~m;
    u = uu;
    x = a;
    y = b;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    chk({tag, "_lat"}, 128'(n), 128'd33);
  endtask

  task automatic stop_op;
    run_mul = 1'b0;
    run_div = 1'b0;
    tick;
  endtask

  task automatic chk_div(input string tag, input logic [31:0] q,
                         input logic [31:0] r, input logic dz);
    chk({tag, "_quot"}, 128'(quot), 128'(q));
    chk({tag, "_rem"},  128'(rem),  128'(r));
    chk({tag, "_divz"}, 128'(divz), 128'(dz));
  endtask

  initial begin
    rst = 1'b1;
    start(1'b1, 1'b0, 32'd3, 32'd5);
    tick;
    tick;
    chk("rst_stall", 128'(stall), 128'd0);
    chk("rst_z",     128'(z),     128'd0);
    chk_div("rst", 32'd0, 32'd0, 1'b0);

    rst = 1'b0;
    wait_done("post_rst");
    chk("post_rst_z", 128'(z), 128'd15);
    stop_op;

    start(1'b1, 1'b1, 32'hFFFFFFFD, 32'd7);
    wait_done("smul");
    chk("smul_z", 128'(z), 128'hFFFFFFFF_FFFFFFEB);
    stop_op;

    start(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("umul");
    chk("umul_z", 128'(z), 128'hFFFFFFFE_00000001);
    stop_op;

    start(1'b1, 1'b1, 32'h80000000, 32'h80000000);
    wait_done("mneg2");
    chk("mneg2_z", 128'(z), 128'h40000000_00000000);
    stop_op;

    start(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("mnegm1");
    chk("mnegm1_z", 128'(z), 128'h00000000_80000000);
    stop_op;

    start(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done("sdiv");
    chk_div("sdiv", 32'hFFFFFFFC, 32'd1, 1'b0);
    stop_op;

    start(1'b0, 1'b0, 32'hFFFFFFFF, 32'h10);
    wait_done("udiv");
    chk_div("udiv", 32'h0FFFFFFF, 32'hF, 1'b0);
    stop_op;

    start(1'b0, 1'b1, 32'h80000000, 32'd1);
    wait_done("dmin");
    chk_div("dmin", 32'h80000000, 32'd0, 1'b0);
    stop_op;

    start(1'b0, 1'b1, 32'hFFFFFFF8, 32'd2);
    wait_done("dexact");
    chk_div("dexact", 32'hFFFFFFFC, 32'd0, 1'b0);
    stop_op;

    start(1'b0, 1'b1, 32'h64, 32'hFFFFFFF0);
    wait_done("dbigy");
    chk_div("dbigy", 32'd0, 32'h64, 1'b0);
    stop_op;

    start(1'b0, 1'b0, 32'h1234, 32'd0);
    wait_done("dz");
    chk_div("dz", 32'hFFFFFFFF, 32'h1234, 1'b1);
    stop_op;

    start(1'b1, 1'b0, 32'd3, 32'd5);
    wait_done("mul_dz");
    chk("mul_dz_z", 128'(z), 128'd15);
    chk_div("mul_dz", 32'hFFFFFFFF, 32'h1234, 1'b1);
    stop_op;

    start(1'b0, 1'b0, 32'd10, 32'd3);
    wait_done("dclr");
    chk_div("dclr", 32'd3, 32'd1, 1'b0);
    stop_op;

    start(1'b1, 1'b0, 32'd6, 32'd7);
    wait_done("b2b1");
    chk("b2b1_z", 128'(z), 128'd42);
    x = 32'd2;
    y = 32'd3;
    tick;
    chk("b2b_restall", 128'(stall), 128'd1);
    wait_done("b2b2");
    chk("b2b2_z", 128'(z), 128'd6);
    stop_op;

    start(1'b0, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 6; i++) tick;
    run_div = 1'b0;
    tick;
    chk("abort_z", 128'(z), 128'd6);
    chk_div("abort", 32'd3, 32'd1, 1'b0);
    start(1'b1, 1'b0, 32'd4, 32'd4);
    wait_done("after_abort");
    chk("after_abort_z", 128'(z), 128'd16);
    stop_op;

    start(1'b0, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b1;
    #1;
    chk("mrst_stall", 128'(stall), 128'd0);
    tick;
    chk("mrst_stall2", 128'(stall), 128'd0);
    chk("mrst_z", 128'(z), 128'd0);
    chk_div("mrst", 32'd0, 32'd0, 1'b0);
    run_div = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) tick;
    chk("mrst_idle_stall", 128'(stall), 128'd0);
    chk_div("mrst_hold", 32'd0, 32'd0, 1'b0);

    start(1'b0, 1'b0, 32'd100, 32'd7);
    wait_done("mrst_next");
    chk_div("mrst_next", 32'd14, 32'd2, 1'b0);
    stop_op;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH), iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 run_mul  input  1  request multiply; held high until stall observed low.
REQ-006 run_div  input  1  request divide; held high until stall observed low.
REQ-007 u  input  1  1 = signed (two's complement), 0 = unsigned.
REQ-008 x  input  WIDTH  multiplicand / dividend.
REQ-009 y  input  WIDTH  multiplier / divisor.
REQ-010 stall  output  1  combinational; 1 = result not ready, requester must hold.
REQ-011 z  output  2*WIDTH  product.
REQ-012 quot  output  WIDTH  quotient.
REQ-013 rem  output  WIDTH  remainder.
REQ-014 divz  output  1  last divide had y == 0.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; one result bit (div) or one partial-product step (mul) per BUSY cycle.
REQ-016 IDLE with run_mul|run_div: latch x, y, u and op, clear counter, go BUSY; run_mul wins when both are high.
REQ-017 BUSY: iterate; after exactly WIDTH BUSY cycles go DONE.
REQ-018 DONE: go IDLE unconditionally next cycle.
REQ-019 stall SHALL equal (run_mul|run_div) & (state != DONE) & ~rst.
REQ-020 Latency: run first high in cycle t (IDLE) -> stall high cycles t..t+WIDTH (WIDTH+1 cycles) -> stall low and results valid in cycle t+WIDTH+1.
REQ-021 Back-to-back: run held high through DONE SHALL start the next operation in the following IDLE cycle, sampling x, y, u there.
REQ-022 Abort: run_mul and run_div both low during BUSY SHALL return the FSM to IDLE next cycle; z, quot, rem and divz keep their prior values.
REQ-023 z, quot, rem and divz SHALL update only on the BUSY->DONE transition and hold otherwise.
REQ-024 Multiply: z = x*y, full 2*WIDTH bits, signed or unsigned per u.
REQ-025 Unsigned divide: quot = floor(x/y), rem = x - quot*y.
REQ-026 Signed divide: floored division; rem in [0, y) for y > 0; |x| divided by y as unsigned; if x < 0 and the raw remainder r != 0, quot = -(q+1) and rem = y - r, else quot = -q and rem = 0.
REQ-027 Signed divide with y bit WIDTH-1 set: y treated as unsigned magnitude; result defined by REQ-026 arithmetic modulo 2^WIDTH.
REQ-028 y == 0 (divide): quot = all ones, rem = x, divz = 1; latency unchanged per REQ-020.
REQ-029 Any completed divide with y != 0 SHALL clear divz; multiply SHALL leave divz unchanged.
REQ-030 Signed mode x = most-negative value SHALL produce correct results (e.g. WIDTH=32: 0x80000000 / 1 -> quot 0x80000000, rem 0).

Reset
REQ-031 rst high at a clock edge SHALL force state IDLE, z = 0, quot = 0, rem = 0, divz = 0, counter = 0.
REQ-032 rst mid-operation SHALL discard the in-flight operation; no output updates from it.
REQ-033 stall SHALL be 0 in every cycle rst is high.
REQ-034 First cycle after rst deasserts with run high SHALL be treated as IDLE start per REQ-016.

Verification (WIDTH=32)
REQ-035 run_mul, u=1, x=0xFFFFFFFD, y=7 -> stall high 33 cycles, then z = 0xFFFFFFFF_FFFFFFEB.
REQ-036 run_div, u=1, x=0xFFFFFFF9 (-7), y=2 -> quot 0xFFFFFFFC, rem 1, divz 0.
REQ-037 run_div, u=0, x=0xFFFFFFFF, y=0x10 -> quot 0x0FFFFFFF, rem 0xF.
REQ-038 run_div, x=0x1234, y=0 -> after 33 stall cycles quot 0xFFFFFFFF, rem 0x1234, divz 1; then a mul 3*5 -> z 15, divz still 1.
REQ-039 run_mul held high across two ops (6*7, then 2*3 presented in IDLE) -> z 42 in first DONE, stall high again the next cycle, z 6 in second DONE 34 cycles later.
REQ-040 rst pulsed 10 cycles into a divide -> stall 0 during rst, outputs all 0, FSM IDLE; run low after rst keeps stall 0.
